// File: rtl/pulp_clock_gate_ctrl_if.sv
// Bundles the control inputs and gate-enable outputs of pulp_clock_gate_ctrl.
//   master : drives test_en_i, idle_thresh_i, ch_busy_i, ch_force_on_i and
//            observes clk_en_o, ch_ready_o, all_gated_o
//   slave  : the controller side (inverse directions)
// NumCh / IdleW must match the parameters of the attached controller.
interface pulp_clock_gate_ctrl_if #(
    parameter int NumCh = 4,
    parameter int IdleW = 8
) ();
    logic             test_en_i;
    logic [IdleW-1:0] idle_thresh_i;
    logic [NumCh-1:0] ch_busy_i;
    logic [NumCh-1:0] ch_force_on_i;
    logic [NumCh-1:0] clk_en_o;
    logic [NumCh-1:0] ch_ready_o;
    logic             all_gated_o;

    modport master (
        output test_en_i, idle_thresh_i, ch_busy_i, ch_force_on_i,
        input  clk_en_o, ch_ready_o, all_gated_o
    );

    modport slave (
        input  test_en_i, idle_thresh_i, ch_busy_i, ch_force_on_i,
        output clk_en_o, ch_ready_o, all_gated_o
    );
endinterface

// File: rtl/pulp_clock_gate_ctrl.sv
// Multi-channel clock-gate controller.
// Each channel auto-gates its clock enable after idle_thresh_i consecutive
// idle cycles and re-enables on busy/force_on, reporting ready only after a
// fixed WakeCycles settle period. Enables come straight from flops, with a
// single OR against test_en_i so scan can force every clock on.
// Ports:
//   clk_i  free-running domain clock
//   rst_i  synchronous reset, active-high (all channels return to RUN)
//   bus    pulp_clock_gate_ctrl_if.slave: thresholds, busy/force requests,
//          per-channel clk_en_o / ch_ready_o and the all_gated_o summary

// Per-channel gating FSM with idle and wake counters.
module pulp_clock_gate_ch #(
    parameter int IdleW      = 8,
    parameter int WakeCycles = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IdleW-1:0] thresh_i,
    input  logic             busy_i,
    input  logic             force_i,
    output logic             en_o,
    output logic             ready_o,
    output logic             off_d_o   // next state is OFF
);
    localparam int WakeW = $clog2(WakeCycles + 1);

    typedef enum logic [1:0] {RUN, OFF, WAKE} state_e;

    state_e           state_q, state_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic [WakeW-1:0] wake_q, wake_d;
    logic [IdleW:0]   idle_inc;
    logic             req;

    assign req = busy_i | force_i;
    // One bit wider so count+1 never wraps before the threshold compare.
    assign idle_inc = {1'b0, idle_q} + {{IdleW{1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        wake_d  = wake_q;
        case (state_q)
            RUN: begin
                if (req) begin
                    idle_d = '0;
                end else if (thresh_i != '0) begin
                    // >= so a threshold lowered below the count gates on
                    // the very next idle cycle.
                    if (idle_inc >= {1'b0, thresh_i}) state_d = OFF;
                    if (idle_q != '1) idle_d = idle_inc[IdleW-1:0];
                end
            end
            OFF: begin
                if (req) begin
                    state_d = WAKE;
                    wake_d  = WakeW'(WakeCycles);
                end
            end
            WAKE: begin
                // Wake always completes once started, even if busy drops.
                if (wake_q <= WakeW'(1)) begin
                    state_d = RUN;
                    idle_d  = '0;
                    wake_d  = '0;
                end else begin
                    wake_d = wake_q - WakeW'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            idle_q  <= '0;
            wake_q  <= '0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            wake_q  <= wake_d;
        end
    end

    // Pure decodes of the state flops: glitch-free.
    assign en_o    = (state_q != OFF);
    assign ready_o = (state_q == RUN);
    assign off_d_o = (state_d == OFF);
endmodule

module pulp_clock_gate_ctrl #(
    parameter int NumCh      = 4,
    parameter int IdleW      = 8,
    parameter int WakeCycles = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    pulp_clock_gate_ctrl_if.slave bus
);
    logic [NumCh-1:0] en_q;
    logic [NumCh-1:0] ready_q;
    logic [NumCh-1:0] off_d;
    logic             all_gated_q, all_gated_d;

    for (genvar i = 0; i < NumCh; i++) begin : g_ch
        pulp_clock_gate_ch #(
            .IdleW      (IdleW),
            .WakeCycles (WakeCycles)
        ) u_ch (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .thresh_i (bus.idle_thresh_i),
            .busy_i   (bus.ch_busy_i[i]),
            .force_i  (bus.ch_force_on_i[i]),
            .en_o     (en_q[i]),
            .ready_o  (ready_q[i]),
            .off_d_o  (off_d[i])
        );
    end

    // Registered from next-state so it lines up with the channel states.
    always_comb begin
        all_gated_d = &off_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) all_gated_q <= 1'b0;
        else       all_gated_q <= all_gated_d;
    end

    // Only combinational path: DFT override of the registered enables.
    assign bus.clk_en_o    = en_q | {NumCh{bus.test_en_i}};
    assign bus.ch_ready_o  = ready_q;
    assign bus.all_gated_o = all_gated_q;
endmodule

// File: tb/tb_pulp_clock_gate_ctrl.sv
// Directed bench for pulp_clock_gate_ctrl: a default 4-channel instance plus
// a 2-channel IdleW=2 / WakeCycles=1 instance for narrow-counter corners.
module tb_pulp_clock_gate_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pulp_clock_gate_ctrl_if #(.NumCh(4), .IdleW(8)) bus ();
    pulp_clock_gate_ctrl_if #(.NumCh(2), .IdleW(2)) bus2 ();

    pulp_clock_gate_ctrl #(.NumCh(4), .IdleW(8), .WakeCycles(2)) dut (
        .clk_i (clk), .rst_i (rst), .bus (bus)
    );
    pulp_clock_gate_ctrl #(.NumCh(2), .IdleW(2), .WakeCycles(1)) dut2 (
        .clk_i (clk), .rst_i (rst), .bus (bus2)
    );

    // Advance n edges; sample 1ns after each edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        bus.idle_thresh_i  = '0;
        bus.ch_busy_i      = '0;
        bus.ch_force_on_i  = '0;
        bus.test_en_i      = 1'b0;
        bus2.idle_thresh_i = '0;
        bus2.ch_busy_i     = '0;
        bus2.ch_force_on_i = '0;
        bus2.test_en_i     = 1'b0;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.idle_thresh_i = '0;
        bus.ch_busy_i     = '0;
        rst = 1'b1;
        step(3);
        checks++;
        if (bus.clk_en_o !== 4'hF) begin
            errors++; $display("FAIL reset_en got %h exp %h", bus.clk_en_o, 4'hF);
        end
        checks++;
        if (bus.ch_ready_o !== 4'hF) begin
            errors++; $display("FAIL reset_ready got %h exp %h", bus.ch_ready_o, 4'hF);
        end
        checks++;
        if (bus.all_gated_o !== 1'b0) begin
            errors++; $display("FAIL reset_all_gated got %b exp 0", bus.all_gated_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_autogate();
        do_reset();
        bus.idle_thresh_i = 8'd5;
        bus.ch_busy_i     = 4'b1110;
        step(4);
        checks++;
        if (bus.clk_en_o !== 4'hF) begin
            errors++; $display("FAIL gate_idle4 got %h exp %h", bus.clk_en_o, 4'hF);
        end
        // Busy at idle count 4 restarts the count.
        bus.ch_busy_i = 4'b1111;
        step(1);
        bus.ch_busy_i = 4'b1110;
        step(4);
        checks++;
        if (bus.clk_en_o !== 4'hF) begin
            errors++; $display("FAIL gate_restart got %h exp %h", bus.clk_en_o, 4'hF);
        end
        step(1);
        checks++;
        if (bus.clk_en_o !== 4'hE || bus.ch_ready_o !== 4'hE) begin
            errors++; $display("FAIL gate_5th en %h ready %h exp E E", bus.clk_en_o, bus.ch_ready_o);
        end
        checks++;
        if (bus.all_gated_o !== 1'b0) begin
            errors++; $display("FAIL gate_all_gated got %b exp 0", bus.all_gated_o);
        end
    endtask

    task automatic test_busy_vs_hit();
        do_reset();
        bus.idle_thresh_i = 8'd3;
        bus.ch_busy_i     = 4'b1110;
        step(2);
        bus.ch_busy_i = 4'b1111;   // would be the threshold-hitting cycle
        step(1);
        checks++;
        if (bus.clk_en_o !== 4'hF || bus.ch_ready_o !== 4'hF) begin
            errors++; $display("FAIL busy_wins en %h ready %h exp F F", bus.clk_en_o, bus.ch_ready_o);
        end
        bus.ch_busy_i = 4'b1110;
        step(2);
        checks++;
        if (bus.clk_en_o !== 4'hF) begin
            errors++; $display("FAIL busy_wins_idle2 got %h exp %h", bus.clk_en_o, 4'hF);
        end
        step(1);
        checks++;
        if (bus.clk_en_o !== 4'hE) begin
            errors++; $display("FAIL busy_wins_idle3 got %h exp %h", bus.clk_en_o, 4'hE);
        end
    endtask

    task automatic test_thresh_change();
        do_reset();
        bus.idle_thresh_i = 8'd8;
        bus.ch_busy_i     = 4'b1110;
        step(4);
        checks++;
        if (bus.clk_en_o !== 4'hF) begin
            errors++; $display("FAIL thresh8_idle4 got %h exp %h", bus.clk_en_o, 4'hF);
        end
        bus.idle_thresh_i = 8'd3;  // below current count of 4
        step(1);
        checks++;
        if (bus.clk_en_o !== 4'hE) begin
            errors++; $display("FAIL thresh_lowered got %h exp %h", bus.clk_en_o, 4'hE);
        end
    endtask

    task automatic test_wake();
        do_reset();
        bus.idle_thresh_i = 8'd2;
        step(2);
        checks++;
        if (bus.clk_en_o !== 4'h0 || bus.all_gated_o !== 1'b1) begin
            errors++; $display("FAIL wake_all_off en %h ag %b exp 0 1", bus.clk_en_o, bus.all_gated_o);
        end
        bus.ch_busy_i = 4'b0010;
        step(1);
        bus.ch_busy_i = 4'b0000;
        checks++;
        if (bus.clk_en_o !== 4'h2 || bus.ch_ready_o !== 4'h0 || bus.all_gated_o !== 1'b0) begin
            errors++; $display("FAIL wake_edge0 en %h ready %h ag %b exp 2 0 0",
                               bus.clk_en_o, bus.ch_ready_o, bus.all_gated_o);
        end
        step(1);
        checks++;
        if (bus.clk_en_o !== 4'h2 || bus.ch_ready_o !== 4'h0) begin
            errors++; $display("FAIL wake_edge1 en %h ready %h exp 2 0", bus.clk_en_o, bus.ch_ready_o);
        end
        step(1);
        checks++;
        if (bus.clk_en_o !== 4'h2 || bus.ch_ready_o !== 4'h2) begin
            errors++; $display("FAIL wake_edge2 en %h ready %h exp 2 2", bus.clk_en_o, bus.ch_ready_o);
        end
        step(2);
        checks++;
        if (bus.clk_en_o !== 4'h0 || bus.all_gated_o !== 1'b1) begin
            errors++; $display("FAIL wake_regate en %h ag %b exp 0 1", bus.clk_en_o, bus.all_gated_o);
        end
    endtask

    task automatic test_never_gate();
        do_reset();
        step(300);
        checks++;
        if (bus.clk_en_o !== 4'hF || bus.ch_ready_o !== 4'hF || bus.all_gated_o !== 1'b0) begin
            errors++; $display("FAIL never_gate en %h ready %h ag %b exp F F 0",
                               bus.clk_en_o, bus.ch_ready_o, bus.all_gated_o);
        end
        bus.idle_thresh_i = 8'd3;
        bus.ch_force_on_i = 4'b0100;
        step(3);
        checks++;
        if (bus.clk_en_o !== 4'h4 || bus.all_gated_o !== 1'b0) begin
            errors++; $display("FAIL force_hold en %h ag %b exp 4 0", bus.clk_en_o, bus.all_gated_o);
        end
        step(20);
        checks++;
        if (bus.clk_en_o !== 4'h4 || bus.ch_ready_o !== 4'h4) begin
            errors++; $display("FAIL force_long en %h ready %h exp 4 4", bus.clk_en_o, bus.ch_ready_o);
        end
        bus.ch_force_on_i = 4'b0000;
        step(3);
        checks++;
        if (bus.clk_en_o !== 4'h0 || bus.all_gated_o !== 1'b1) begin
            errors++; $display("FAIL force_release en %h ag %b exp 0 1", bus.clk_en_o, bus.all_gated_o);
        end
    endtask

    task automatic test_dft();
        do_reset();
        bus.idle_thresh_i = 8'd1;
        step(1);
        checks++;
        if (bus.clk_en_o !== 4'h0 || bus.all_gated_o !== 1'b1) begin
            errors++; $display("FAIL dft_off en %h ag %b exp 0 1", bus.clk_en_o, bus.all_gated_o);
        end
        bus.test_en_i = 1'b1;
        #1;
        checks++;
        if (bus.clk_en_o !== 4'hF || bus.ch_ready_o !== 4'h0 || bus.all_gated_o !== 1'b1) begin
            errors++; $display("FAIL dft_on en %h ready %h ag %b exp F 0 1",
                               bus.clk_en_o, bus.ch_ready_o, bus.all_gated_o);
        end
        step(3);
        checks++;
        if (bus.ch_ready_o !== 4'h0 || bus.all_gated_o !== 1'b1) begin
            errors++; $display("FAIL dft_fsm ready %h ag %b exp 0 1", bus.ch_ready_o, bus.all_gated_o);
        end
        bus.test_en_i = 1'b0;
        #1;
        checks++;
        if (bus.clk_en_o !== 4'h0) begin
            errors++; $display("FAIL dft_release got %h exp %h", bus.clk_en_o, 4'h0);
        end
    endtask

    task automatic test_reset_mid_wake();
        do_reset();
        bus.idle_thresh_i = 8'd2;
        step(2);
        bus.ch_busy_i = 4'b0010;
        step(1);
        bus.ch_busy_i = 4'b0000;
        checks++;
        if (bus.clk_en_o !== 4'h2 || bus.ch_ready_o !== 4'h0) begin
            errors++; $display("FAIL rwake_in_wake en %h ready %h exp 2 0", bus.clk_en_o, bus.ch_ready_o);
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checks++;
        if (bus.clk_en_o !== 4'hF || bus.ch_ready_o !== 4'hF || bus.all_gated_o !== 1'b0) begin
            errors++; $display("FAIL rwake_run en %h ready %h ag %b exp F F 0",
                               bus.clk_en_o, bus.ch_ready_o, bus.all_gated_o);
        end
    endtask

    task automatic test_narrow();
        do_reset();
        bus2.idle_thresh_i = 2'd3;   // max value of a 2-bit threshold
        step(2);
        checks++;
        if (bus2.clk_en_o !== 2'b11) begin
            errors++; $display("FAIL narrow_idle2 got %b exp 11", bus2.clk_en_o);
        end
        step(1);
        checks++;
        if (bus2.clk_en_o !== 2'b00 || bus2.all_gated_o !== 1'b1) begin
            errors++; $display("FAIL narrow_gate en %b ag %b exp 00 1", bus2.clk_en_o, bus2.all_gated_o);
        end
        bus2.ch_busy_i = 2'b01;
        step(1);
        bus2.ch_busy_i = 2'b00;
        checks++;
        if (bus2.clk_en_o !== 2'b01 || bus2.ch_ready_o !== 2'b00) begin
            errors++; $display("FAIL narrow_wake en %b ready %b exp 01 00", bus2.clk_en_o, bus2.ch_ready_o);
        end
        step(1);
        checks++;
        if (bus2.ch_ready_o !== 2'b01) begin
            errors++; $display("FAIL narrow_ready got %b exp 01", bus2.ch_ready_o);
        end
    endtask

    initial begin
        bus.test_en_i      = 1'b0;
        bus.idle_thresh_i  = '0;
        bus.ch_busy_i      = '0;
        bus.ch_force_on_i  = '0;
        bus2.test_en_i     = 1'b0;
        bus2.idle_thresh_i = '0;
        bus2.ch_busy_i     = '0;
        bus2.ch_force_on_i = '0;
        test_reset();
        test_autogate();
        test_busy_vs_hit();
        test_thresh_change();
        test_wake();
        test_never_gate();
        test_dft();
        test_reset_mid_wake();
        test_narrow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
